// File: rtl/mem_pkg.sv
// Shared constants and types for the external-memory burst read path.
package mem_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 16;

    localparam logic [ADDR_W-1:0] MODEL_BASE = 24'h000000;
    localparam logic [ADDR_W-1:0] INPUT_BASE = 24'h400000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Word as held in the output buffer: data plus end-of-burst tag.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } rd_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; storage cleared so the head reads zero after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Upstream credit accounting must never push into a full buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full))
                else $error("sync_fifo: push into full buffer");
        end
    end

endmodule

// File: rtl/ext_mem_burst_reader.sv
// Burst read engine: turns (addr, len) commands into single-word memory
// reads and streams the returned words out with a last flag.
module ext_mem_burst_reader
    import mem_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              pend_q, pend_d;
    logic              pend_last_q, pend_last_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_pop;
    rd_word_t          push_word;
    rd_word_t          head_word;
    logic [SUM_W-1:0]  credit_used;
    logic              credit_ok;
    logic              issue;

    // Words already buffered plus the one in flight must leave a free slot
    assign credit_used = SUM_W'(fifo_count) + SUM_W'(pend_q);
    assign credit_ok   = (credit_used < SUM_W'(FIFO_DEPTH));
    assign issue       = (state_q == ISSUE) && (rem_q != '0) && credit_ok;

    // Memory answers one cycle after the strobe; capture it with its tag
    assign push_word.last = pend_last_q;
    assign push_word.data = mem_rd_data;
    assign fifo_pop       = !fifo_empty && out_ready;

    sync_fifo #(
        .WIDTH ($bits(rd_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pend_q),
        .push_data (push_word),
        .pop       (fifo_pop),
        .pop_data  (head_word),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Next-state and command/issue bookkeeping
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        pend_d      = issue;
        pend_last_d = issue && (rem_q == LEN_W'(1));
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        addr_d  = cmd_addr;
                        rem_d   = cmd_len;
                        state_d = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The tagged word is the final push, so its pop empties the path
                if (fifo_pop && head_word.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset also drops any response still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign mem_re      = issue;
    assign mem_rd_addr = addr_q;
    assign out_valid   = !fifo_empty;
    assign out_data    = head_word.data;
    assign out_last    = !fifo_empty && head_word.last;
    assign done        = done_q;

endmodule

// File: doc/ext_mem_burst_reader.md
# ext_mem_burst_reader

Burst read engine directly upstream of the compute datapath and downstream of the external memory model. Accepts a command (base word address, length), issues single-word reads to external memory and absorbs its 1-cycle registered read latency. Returns the words as a valid/ready stream with a last flag. Used to stream model weights from address 0 and input data from address 4194304 into on-chip buffers.

## Interface
- ADDR_W, 24, external memory word-address width
- DATA_W, 32, data word width
- LEN_W, 16, burst length field width (words)
- FIFO_DEPTH, 4, output buffer depth (power of 2, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  ADDR_W  first word address
- cmd_len  in  LEN_W  number of words
- mem_re  out  1  read strobe to external memory
- mem_rd_addr  out  ADDR_W  read address, valid with mem_re
- mem_rd_data  in  DATA_W  read data, valid the cycle after mem_re
- out_valid  out  1  stream word available
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W  stream word
- out_last  out  1  marks final word of burst
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at burst completion

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1, busy=0.
  - Handshake with cmd_len≠0: latch addr_q=cmd_addr, remaining=cmd_len, go to ISSUE.
  - Handshake with cmd_len=0: done pulses next cycle, stay IDLE, no memory access.
- ISSUE: cmd_ready=0, busy=1.
  - mem_re = (remaining≠0) & (fifo_count + pend < FIFO_DEPTH).
  - pend = 1 when the previous cycle issued a read (at most one outstanding).
  - Each issue: mem_rd_addr=addr_q, then addr_q+1 mod 2^ADDR_W (wraps 0xFFFFFF→0x000000) and remaining−1.
  - Issue of remaining=1 goes to DRAIN.
- Response: the cycle after mem_re, mem_rd_data is pushed into the FIFO. A tag bit stored with the word is 1 iff it was the final issued read.
- DRAIN: no issues. When FIFO empty, pend=0 and the last word has been handshaken, go to IDLE and pulse done.
- Output: out_valid = FIFO non-empty; out_data/out_last come from the FIFO head; pop on out_valid & out_ready.
  - out_data holds stable while out_valid & !out_ready.
- Simultaneous push and pop in one cycle: count unchanged, both take effect.
- Credit check includes pend, so the FIFO never overflows. A push to a full FIFO is a design error; assertion required.
- Reset (any time, including mid-burst): FSM→IDLE, FIFO emptied, pend cleared. A memory response arriving after reset is discarded.
- Reset values: cmd_ready=1, mem_re=0, mem_rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.

## Timing
- Command handshake at edge E0. First mem_re in the cycle after E0. Data is pushed at the following edge. out_valid rises 3 cycles after E0.
- With out_ready held high: one word per cycle sustained; total len+3 cycles from accept to last handshake.
- done is asserted the cycle after the out_last handshake. cmd_ready returns in that same cycle, so back-to-back commands have a 1-cycle bubble.
- Backpressure: with out_ready=0, issuing stops once fifo_count+pend=FIFO_DEPTH. Issuing resumes the cycle after a pop.
- mem_re and mem_rd_addr are registered-state-derived combinational outputs; there is no combinational path from out_ready to mem_re.

## Structure
- Shared package mem_pkg: ADDR_W, DATA_W, LEN_W constants, rd_state_t enum {IDLE, ISSUE, DRAIN}, MODEL_BASE=24'h000000, INPUT_BASE=24'h400000.
- Sub-module: sync_fifo (parameterised width/depth, count output, push/pop, async reset). Instantiated with width DATA_W+1 to carry the last tag.

## Test plan
- Basic burst: cmd_addr=0x000010, len=4, memory preloaded mem[0x10+i]=0xA0+i, out_ready=1 → words 0xA0..0xA3; out_last on 0xA3 only; done 1 cycle later; first out_valid 3 cycles after accept.
- Backpressure: len=10, out_ready toggled 1-0-0-1 repeatedly → all 10 words in order, no loss or duplicate, fifo_count ≤ 4, mem_re stops while full.
- Address wrap: cmd_addr=0xFFFFFE, len=4 → reads at 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- Zero length: cmd_len=0 → no mem_re, no out_valid, done pulses once, cmd_ready stays 1.
- Reset mid-burst: assert rst during the 3rd word of len=8 → all outputs at reset values immediately. A new len=2 command after release returns exactly its 2 words with no stale data.
- Back-to-back: INPUT_BASE len=3, then MODEL_BASE len=2 presented on done → 5 words, two out_last pulses, two done pulses.
